// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared UART constants and transmitter FSM state encoding
package uart_tx_pkg;

    localparam int CLKS_PER_BIT_DEF = 16;
    localparam int DATA_BITS        = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: small synchronous byte FIFO with registered occupancy count
module uart_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr,
    input  logic       rd,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem_q [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0] cnt_q;
    logic        we, re;

    assign full  = cnt_q == (AW+1)'(DEPTH);
    assign empty = cnt_q == '0;
    assign we    = wr & ~full;
    assign re    = rd & ~empty;
    assign dout  = mem_q[rp_q];

    // pointers wrap naturally; a write while full is dropped even if a pop happens
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_q + AW'(we);
            rp_q  <= rp_q + AW'(re);
            cnt_q <= cnt_q + (AW+1)'(we) - (AW+1)'(re);
        end
    end

    // storage needs no reset; entries are only read once counted in
    always_ff @(posedge clk) begin
        if (we) mem_q[wp_q] <= din;
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 LSB-first serial transmitter fed by a small write FIFO
module uart_tx import uart_tx_pkg::*; #(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int FIFO_DEPTH   = 4,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_wr,
    output logic       tx_full,
    output logic       txd,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int CW = $clog2(STOP_BITS * CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

    tx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;
    logic          pop, empty;
    logic [7:0]    fifo_dout;

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .wr    (tx_wr),
        .rd    (pop),
        .din   (tx_data),
        .dout  (fifo_dout),
        .full  (tx_full),
        .empty (empty)
    );

    assign txd     = txd_q;
    assign tx_busy = (state_q != IDLE) | ~empty;
    assign tx_done = (state_q == STOP) & (cnt_q == STOP_LAST);

    // frame sequencing; STOP chains straight into START when more bytes wait
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    state_d = (bit_q == LAST_BIT) ? STOP : DATA;
                end
            end
            STOP: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == STOP_LAST) begin
                    cnt_d   = '0;
                    pop     = ~empty;
                    shift_d = empty ? shift_q : fifo_dout;
                    state_d = empty ? IDLE : START;
                end
            end
            default: state_d = IDLE;
        endcase
        txd_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] : 1'b1;
    end

    // line register is loaded from the next state so txd lines up with state_q
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
        end
    end

endmodule
